// File: rtl/rev_gate_pipe.sv
// rev_gate_pipe: STAGES registered layers of per-lane 3-bit reversible gates.
// Each beat carries its own gate mode. Between layers the triple is rotated
// (q,r,s) <- (u,v,t). Valid/ready flow control lets a bubble in any layer be
// filled while the output is stalled.
// STAGES must be in the range 1..8.
module rev_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_q,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_t,
    output logic [WIDTH-1:0] out_u,
    output logic [WIDTH-1:0] out_v,
    output logic [1:0]       out_mode,
    output logic [15:0]      beat_cnt
);

    // Stage registers; index 0 is the first layer, STAGES-1 drives the outputs.
    logic [STAGES-1:0][WIDTH-1:0] r_t;
    logic [STAGES-1:0][WIDTH-1:0] r_u;
    logic [STAGES-1:0][WIDTH-1:0] r_v;
    logic [STAGES-1:0][1:0]       r_mode;
    logic [STAGES-1:0]            r_vld;
    logic [15:0]                  r_cnt;

    // Gate operands feeding each layer, and the gate results.
    logic [STAGES-1:0][WIDTH-1:0] w_q;
    logic [STAGES-1:0][WIDTH-1:0] w_r;
    logic [STAGES-1:0][WIDTH-1:0] w_s;
    logic [STAGES-1:0][1:0]       w_mode;
    logic [STAGES-1:0]            w_vin;
    logic [STAGES-1:0][WIDTH-1:0] w_t;
    logic [STAGES-1:0][WIDTH-1:0] w_u;
    logic [STAGES-1:0][WIDTH-1:0] w_v;
    logic [STAGES-1:0]            w_open;
    logic                         w_out_fire;

    // Layer inputs: layer 0 takes the ports, later layers take the rotated previous result.
    always_comb begin
        w_q[0]    = in_q;
        w_r[0]    = in_r;
        w_s[0]    = in_s;
        w_mode[0] = in_mode;
        w_vin[0]  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_q[k]    = r_u[k-1];
            w_r[k]    = r_v[k-1];
            w_s[k]    = r_t[k-1];
            w_mode[k] = r_mode[k-1];
            w_vin[k]  = r_vld[k-1];
        end
    end

    // Per-lane reversible gate for every layer, selected by the beat's own mode.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_t[k] = w_q[k];
            case (w_mode[k])
                2'd0: begin
                    w_u[k] = w_r[k];
                    w_v[k] = (w_q[k] | w_r[k]) ^ w_s[k];
                end
                2'd1: begin
                    w_u[k] = w_r[k];
                    w_v[k] = (w_q[k] & w_r[k]) ^ w_s[k];
                end
                2'd2: begin
                    w_u[k] = w_q[k] ^ w_r[k];
                    w_v[k] = (w_q[k] & w_r[k]) ^ w_s[k];
                end
                default: begin
                    w_u[k] = w_q[k] ^ w_r[k];
                    w_v[k] = (w_q[k] & ~w_r[k]) ^ w_s[k];
                end
            endcase
        end
    end

    // A layer may load when it or any layer downstream of it is empty, or the output drains.
    // Computed from register state only so there is no combinational chain through w_open.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_open[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!r_vld[j]) begin
                    w_open[k] = 1'b1;
                end
            end
        end
    end

    assign w_out_fire = r_vld[STAGES-1] & out_ready;
    assign in_ready   = rst_n & w_open[0];

    // Pipeline layers and the handshake counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_t    <= '0;
            r_u    <= '0;
            r_v    <= '0;
            r_mode <= '0;
            r_cnt  <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_open[k]) begin
                    r_vld[k]  <= w_vin[k];
                    r_t[k]    <= w_t[k];
                    r_u[k]    <= w_u[k];
                    r_v[k]    <= w_v[k];
                    r_mode[k] <= w_mode[k];
                end
            end
            if (w_out_fire) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign out_t     = r_t[STAGES-1];
    assign out_u     = r_u[STAGES-1];
    assign out_v     = r_v[STAGES-1];
    assign out_mode  = r_mode[STAGES-1];
    assign beat_cnt  = r_cnt;

endmodule

// File: tb/tb_rev_gate_pipe.sv
// Bench for rev_gate_pipe: one single-layer instance (a_*) and one
// three-layer instance (b_*) sharing clock and reset.
module tb_rev_gate_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]  a_in_mode, a_out_mode;
    logic [7:0]  a_in_q, a_in_r, a_in_s, a_out_t, a_out_u, a_out_v;
    logic [15:0] a_beat_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [1:0]  b_in_mode, b_out_mode;
    logic [7:0]  b_in_q, b_in_r, b_in_s, b_out_t, b_out_u, b_out_v;
    logic [15:0] b_beat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [25:0] expq[$];

    rev_gate_pipe #(.WIDTH(8), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
        .in_q(a_in_q), .in_r(a_in_r), .in_s(a_in_s),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_t(a_out_t), .out_u(a_out_u), .out_v(a_out_v),
        .out_mode(a_out_mode), .beat_cnt(a_beat_cnt)
    );

    rev_gate_pipe #(.WIDTH(8), .STAGES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
        .in_q(b_in_q), .in_r(b_in_r), .in_s(b_in_s),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_t(b_out_t), .out_u(b_out_u), .out_v(b_out_v),
        .out_mode(b_out_mode), .beat_cnt(b_beat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference gate: returns {t,u,v}
    function automatic logic [23:0] gate(input logic [1:0] m, input logic [7:0] q, input logic [7:0] r, input logic [7:0] s);
        logic [7:0] u, v;
        case (m)
            2'd0: begin u = r;     v = (q | r) ^ s;  end
            2'd1: begin u = r;     v = (q & r) ^ s;  end
            2'd2: begin u = q ^ r; v = (q & r) ^ s;  end
            default: begin u = q ^ r; v = (q & ~r) ^ s; end
        endcase
        return {q, u, v};
    endfunction

    // Three layers with rotation (q,r,s) <- (u,v,t) between them: returns {mode,t,u,v}
    function automatic logic [25:0] model3(input logic [1:0] m, input logic [7:0] q, input logic [7:0] r, input logic [7:0] s);
        logic [23:0] g;
        logic [7:0]  t, u, v;
        g = gate(m, q, r, s);
        for (int k = 1; k < 3; k++) begin
            {t, u, v} = g;
            g = gate(m, u, v, t);
        end
        return {m, g};
    endfunction

    initial begin
        int sent;
        int got;
        int guard;
        logic [1:0] m;
        logic [7:0] q, r, s;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_mode = 2'd0; a_in_q = 8'h00; a_in_r = 8'h00; a_in_s = 8'h00; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_mode = 2'd0; b_in_q = 8'h00; b_in_r = 8'h00; b_in_s = 8'h00; b_out_ready = 1'b1;
        #3;
        chk("rst_a_in_ready", a_in_ready, 0);
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_beat_cnt", a_beat_cnt, 0);
        chk("rst_a_out_data", {a_out_mode, a_out_t, a_out_u, a_out_v}, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_out_data", {b_out_mode, b_out_t, b_out_u, b_out_v}, 0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single layer, mode 0, first edge after reset release
        a_in_valid = 1'b1; a_in_mode = 2'd0; a_in_q = 8'hF0; a_in_r = 8'h0C; a_in_s = 8'hAA;
        #1;
        chk("a_first_in_ready", a_in_ready, 1);
        @(negedge clk);
        chk("a_m0_valid", a_out_valid, 1);
        chk("a_m0_data", {a_out_mode, a_out_t, a_out_u, a_out_v}, {2'd0, 8'hF0, 8'h0C, 8'h56});
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("a_m0_cnt", a_beat_cnt, 1);
        chk("a_m0_drained", a_out_valid, 0);

        // mode 2 then mode 3 on its output restores the original triple
        a_in_valid = 1'b1; a_in_mode = 2'd2; a_in_q = 8'h3C; a_in_r = 8'h5A; a_in_s = 8'h0F;
        @(negedge clk);
        chk("a_m2_data", {a_out_mode, a_out_t, a_out_u, a_out_v}, {2'd2, 8'h3C, 8'h66, 8'h17});
        a_in_mode = 2'd3; a_in_q = a_out_t; a_in_r = a_out_u; a_in_s = a_out_v;
        @(negedge clk);
        chk("a_m3_restore", {a_out_mode, a_out_t, a_out_u, a_out_v}, {2'd3, 8'h3C, 8'h5A, 8'h0F});

        // mode 1 applied twice is the identity
        a_in_mode = 2'd1; a_in_q = 8'hA5; a_in_r = 8'h3C; a_in_s = 8'h99;
        @(negedge clk);
        chk("a_m1_fwd", {a_out_mode, a_out_t, a_out_u, a_out_v}, {2'd1, 8'hA5, 8'h3C, 8'hBD});
        a_in_q = a_out_t; a_in_r = a_out_u; a_in_s = a_out_v;
        @(negedge clk);
        chk("a_m1_inv", {a_out_mode, a_out_t, a_out_u, a_out_v}, {2'd1, 8'hA5, 8'h3C, 8'h99});
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("a_cnt5", a_beat_cnt, 5);
        chk("a_idle", a_out_valid, 0);

        // three layers, directed vector, latency and mode carried with the beat
        b_in_valid = 1'b1; b_in_mode = 2'd1; b_in_q = 8'hFF; b_in_r = 8'h0F; b_in_s = 8'h00;
        @(negedge clk);
        b_in_valid = 1'b0; b_in_mode = 2'd3;
        chk("b_lat_n1", b_out_valid, 0);
        @(negedge clk);
        chk("b_lat_n2", b_out_valid, 0);
        @(negedge clk);
        chk("b_lat_n3", b_out_valid, 1);
        chk("b_m1_rot", {b_out_mode, b_out_t, b_out_u, b_out_v}, {2'd1, 8'h0F, 8'hF0, 8'h0F});
        @(negedge clk);
        chk("b_lat_n4", b_out_valid, 0);
        chk("b_cnt1", b_beat_cnt, 1);

        // 20 random beats back to back, out_ready high
        for (int i = 0; i < 22; i++) begin
            if (i < 20) begin
                m = 2'($urandom_range(0, 3));
                q = 8'($urandom); r = 8'($urandom); s = 8'($urandom);
                b_in_valid = 1'b1; b_in_mode = m; b_in_q = q; b_in_r = r; b_in_s = s;
                expq.push_back(model3(m, q, r, s));
                #1;
                chk("rand_in_ready", b_in_ready, 1);
            end else begin
                b_in_valid = 1'b0;
            end
            @(negedge clk);
            if (i >= 2) begin
                chk("rand_out_valid", b_out_valid, 1);
                chk("rand_out_data", {b_out_mode, b_out_t, b_out_u, b_out_v}, expq.pop_front());
            end else begin
                chk("rand_lat_empty", b_out_valid, 0);
            end
        end
        @(negedge clk);
        chk("rand_drained", b_out_valid, 0);
        chk("rand_cnt", b_beat_cnt, 21);

        // stall for 5 cycles with continuous input, then release
        sent = 0;
        got  = 0;
        for (int c = 0; c < 30; c++) begin
            b_out_ready = (c >= 5);
            if (sent < 8) begin
                m = 2'(sent);
                q = 8'(sent * 35); r = 8'(8'hC3 ^ 8'(sent)); s = 8'(8'h5A + 8'(sent));
                b_in_valid = 1'b1; b_in_mode = m; b_in_q = q; b_in_r = r; b_in_s = s;
            end else begin
                b_in_valid = 1'b0;
            end
            #1;
            if (c < 5) chk($sformatf("stall_in_ready_c%0d", c), b_in_ready, (c < 3));
            if (c == 3 || c == 4) chk("stall_out_valid", b_out_valid, 1);
            if (b_out_valid) begin
                if (expq.size() == 0) begin
                    chk("stall_extra_beat", b_out_valid, 0);
                end else begin
                    chk("stall_out_data", {b_out_mode, b_out_t, b_out_u, b_out_v}, expq[0]);
                    if (b_out_ready) begin
                        void'(expq.pop_front());
                        got++;
                    end
                end
            end
            if (b_in_valid && b_in_ready) begin
                expq.push_back(model3(m, q, r, s));
                sent++;
            end
            @(negedge clk);
        end
        chk("stall_sent", sent, 8);
        chk("stall_got", got, 8);
        chk("stall_cnt", b_beat_cnt, 29);

        // reset with three beats in flight
        b_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1'b1; b_in_mode = 2'd2; b_in_q = 8'(i + 1); b_in_r = 8'h77; b_in_s = 8'h21;
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        chk("flight_full_valid", b_out_valid, 1);
        chk("flight_full_in_ready", b_in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", b_out_valid, 0);
        chk("midrst_cnt", b_beat_cnt, 0);
        chk("midrst_in_ready", b_in_ready, 0);
        chk("midrst_out_data", {b_out_mode, b_out_t, b_out_u, b_out_v}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_mode = 2'd0; b_in_q = 8'hF0; b_in_r = 8'h0C; b_in_s = 8'hAA;
        #1;
        chk("post_rst_in_ready", b_in_ready, 1);
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("no_stale_n1", b_out_valid, 0);
        @(negedge clk);
        chk("no_stale_n2", b_out_valid, 0);
        @(negedge clk);
        chk("post_rst_valid", b_out_valid, 1);
        chk("post_rst_data", {b_out_mode, b_out_t, b_out_u, b_out_v}, {2'd0, 8'h56, 8'hAE, 8'hF2});
        @(negedge clk);
        chk("post_rst_drained", b_out_valid, 0);
        chk("post_rst_cnt", b_beat_cnt, 1);

        // counter wrap at 16'hFFFF
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        b_in_valid = 1'b1; b_in_mode = 2'd1; b_in_q = 8'h12; b_in_r = 8'h34; b_in_s = 8'h56;
        guard = 0;
        while (b_beat_cnt !== 16'hFFFF && guard < 70000) begin
            @(negedge clk);
            guard++;
        end
        chk("wrap_reached", b_beat_cnt, 16'hFFFF);
        b_in_valid = 1'b0;
        chk("wrap_out_valid", b_out_valid, 1);
        @(negedge clk);
        chk("wrap_zero", b_beat_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_drained", b_out_valid, 0);
        chk("wrap_cnt2", b_beat_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rev_gate_pipe.md
REV_GATE_PIPE -- requirements
Module: rev_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8: bit-lanes per operand; each lane is an independent 3-bit reversible gate.
REQ-002 Parameter STAGES, default 3, legal range 1..8: number of registered gate layers.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block can accept an input beat.
REQ-007 in_mode  input  2  gate select: 0 BJN, 1 Toffoli, 2 Peres, 3 inverse Peres.
REQ-008 in_q, in_r, in_s  input  WIDTH each  operand vectors.
REQ-009 out_valid  output  1  output beat present.
REQ-010 out_ready  input  1  downstream accepts the beat.
REQ-011 out_t, out_u, out_v  output  WIDTH each  result vectors.
REQ-012 out_mode  output  2  mode carried with the beat.
REQ-013 beat_cnt  output  16  count of completed output beats.

Function
REQ-014 Per lane i, gate g(q,r,s)->(t,u,v) SHALL be: mode 0: t=q, u=r, v=(q|r)^s; mode 1: t=q, u=r, v=(q&r)^s; mode 2: t=q, u=q^r, v=(q&r)^s; mode 3: t=q, u=q^r, v=(q&~r)^s.
REQ-015 Mode 3 SHALL exactly invert mode 2; modes 0 and 1 SHALL be self-inverse.
REQ-016 Stage k (1..STAGES) SHALL register g applied to the stage k-1 triple; stage 0 is (in_q,in_r,in_s).
REQ-017 Between consecutive stages the triple SHALL rotate: next stage q=u, r=v, s=t of the previous stage's result; no rotation after the last stage.
REQ-018 Mode SHALL be captured with the beat and travel with it; each beat uses its own mode regardless of later in_mode changes.
REQ-019 Each stage SHALL hold a valid bit; a stage loads when it is empty or its contents advance in the same cycle.
REQ-020 in_ready SHALL equal (stage 1 empty) OR (stage 1 advances this cycle); combinational from out_ready permitted.
REQ-021 A beat SHALL be accepted when in_valid and in_ready are both high; output is handed off when out_valid and out_ready are both high.
REQ-022 Unstalled latency SHALL be exactly STAGES cycles from acceptance edge to out_valid high.
REQ-023 Full throughput: with out_ready held high, one beat per cycle SHALL be accepted and delivered, no bubbles.
REQ-024 With out_ready low and all stages valid, in_ready SHALL be low and all stage registers SHALL hold unchanged.
REQ-025 A bubble (empty stage) SHALL be filled while downstream is stalled; pipeline compacts.
REQ-026 out_t/out_u/out_v/out_mode SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 beat_cnt SHALL increment by 1 on each output handshake and wrap 16'hFFFF -> 0.
REQ-028 Simultaneous accept and deliver SHALL be lossless; beat order SHALL be preserved.
REQ-029 Data registers of invalid stages are don't-care; outputs are qualified only by out_valid.

Reset
REQ-030 On rst_n low, all stage valid bits, out_valid and beat_cnt SHALL clear to 0 immediately, independent of clk.
REQ-031 During reset in_ready SHALL be 0; out_t/out_u/out_v/out_mode SHALL be 0.
REQ-032 Reset mid-operation SHALL discard all in-flight beats; none appears after release.
REQ-033 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-034 WIDTH=8, STAGES=1, mode 0, q=8'hF0, r=8'h0C, s=8'hAA, out_ready=1 -> one cycle later t=8'hF0, u=8'h0C, v=8'h56, beat_cnt=1.
REQ-035 STAGES=1, mode 2 then mode 3 fed back-to-back on output of the first (q=8'h3C, r=8'h5A, s=8'h0F) -> second output equals original (8'h3C, 8'h5A, 8'h0F).
REQ-036 STAGES=3, 20 random beats with out_ready held high -> 20 consecutive outputs, latency 3, matching a reference model with rotation, beat_cnt=20.
REQ-037 STAGES=3, out_ready low 5 cycles with continuous in_valid -> in_ready drops after 3 accepts, outputs stable, no loss or duplication after release.
REQ-038 Assert rst_n low with 3 beats in flight -> out_valid=0 immediately, beat_cnt=0, no stale beat after release.
REQ-039 Preload beat_cnt to 16'hFFFF via 65535 beats, then one more handshake -> beat_cnt=0.
